game_flow_controller: RTL

Sequences one game round and drives modeSelector's startGamePulse / lostGamePulse / winGamePulse.
- Tracks remaining aliens and player lives.
- Applies a start-arming delay and post-hit invulnerability window, both timed in video frames.
- Sits between the key/collision logic and modeSelector; lives/aliens counts also feed the score/HUD drawers.

---
 rtl/game_flow_controller_if.sv | 29 ++
 rtl/game_flow_controller.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/game_flow_controller_if.sv
// rtl/game_flow_controller_if.sv - signal bundle between key/collision logic, game_flow_controller and modeSelector/HUD
interface game_flow_controller_if;
    logic       startOfFrame;
    logic       startKey;
    logic       alienHit;
    logic       playerHit;
    logic       aliensAtBottom;
    logic       startGamePulse;
    logic       lostGamePulse;
    logic       winGamePulse;
    logic       gameActive;
    logic       invulnerable;
    logic [2:0] livesLeft;
    logic [6:0] aliensLeft;

    // Driven by the key/collision side, observed by modeSelector and the HUD drawers
    modport master (
        output startOfFrame, startKey, alienHit, playerHit, aliensAtBottom,
        input  startGamePulse, lostGamePulse, winGamePulse, gameActive, invulnerable,
        input  livesLeft, aliensLeft
    );

    // The game flow controller itself
    modport slave (
        input  startOfFrame, startKey, alienHit, playerHit, aliensAtBottom,
        output startGamePulse, lostGamePulse, winGamePulse, gameActive, invulnerable,
        output livesLeft, aliensLeft
    );
endinterface

// File: rtl/game_flow_controller.sv
// rtl/game_flow_controller.sv - round sequencer (idle/arm/play/invuln/done); optional bonus lives via EXTRA_LIFE_EN
module game_flow_controller #(
    parameter int ALIEN_COUNT      = 40,
    parameter int START_LIVES      = 3,
    parameter int MAX_LIVES        = 5,
    parameter int ARM_FRAMES       = 30,
    parameter int INVULN_FRAMES    = 90,
    parameter int EXTRA_LIFE_KILLS = 20
) (
    input  logic                   clk,
    input  logic                   resetN,
    game_flow_controller_if.slave  gfc
);

    localparam int CNT_MAX = (ARM_FRAMES > INVULN_FRAMES) ? ARM_FRAMES : INVULN_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_PLAY,
        S_INVULN,
        S_DONE
    } state_t;

    state_t           state, stateNext;
    logic [CNT_W-1:0] frameCnt, frameCntNext, frameTick;
    logic [2:0]       lives, livesNext;
    logic [6:0]       aliens, aliensNext;
    logic [3:0]       livesSum;
    logic             keyDly;
    logic             startPulse, lostPulse, winPulse;
    logic             startNext, lostNext, winNext;
    logic             activeR, invulnR;
    logic             alienTaken, hitTaken, bonus;

`ifdef EXTRA_LIFE_EN
    localparam int KILL_W = $clog2(EXTRA_LIFE_KILLS + 1);
    logic [KILL_W-1:0] killCnt, killNext;
`endif

    assign gfc.startGamePulse = startPulse;
    assign gfc.lostGamePulse  = lostPulse;
    assign gfc.winGamePulse   = winPulse;
    assign gfc.gameActive     = activeR;
    assign gfc.invulnerable   = invulnR;
    assign gfc.livesLeft      = lives;
    assign gfc.aliensLeft     = aliens;

    // Next-state and round bookkeeping; lose outranks win, bottom-reach outranks everything
    always_comb begin
        stateNext    = state;
        frameCntNext = frameCnt;
        livesNext    = lives;
        aliensNext   = aliens;
        startNext    = 1'b0;
        lostNext     = 1'b0;
        winNext      = 1'b0;
        alienTaken   = 1'b0;
        hitTaken     = 1'b0;
        bonus        = 1'b0;
        livesSum     = {1'b0, lives};
        frameTick    = frameCnt + CNT_W'(1);
`ifdef EXTRA_LIFE_EN
        killNext     = killCnt;
`endif
        case (state)
            S_IDLE: begin
                if (!keyDly && gfc.startKey) begin
                    stateNext    = S_ARM;
                    frameCntNext = '0;
                end
            end
            S_ARM: begin
                if (gfc.startOfFrame) begin
                    frameCntNext = frameTick;
                    if (frameTick == CNT_W'(ARM_FRAMES)) begin
                        stateNext    = S_PLAY;
                        startNext    = 1'b1;
                        frameCntNext = '0;
                    end
                end
            end
            S_PLAY, S_INVULN: begin
                alienTaken = gfc.alienHit && (aliens != 7'd0);
                hitTaken   = gfc.playerHit && (state == S_PLAY);
                if (alienTaken) begin
                    aliensNext = aliens - 7'd1;
                end
`ifdef EXTRA_LIFE_EN
                if (alienTaken) begin
                    if (killCnt == KILL_W'(EXTRA_LIFE_KILLS - 1)) begin
                        killNext = '0;
                        bonus    = 1'b1;
                    end else begin
                        killNext = killCnt + KILL_W'(1);
                    end
                end
`endif
                // Lives are at least 1 here, so the subtraction cannot wrap
                livesSum = {1'b0, lives} + {3'b000, bonus} - {3'b000, hitTaken};
                if (livesSum > 4'(MAX_LIVES)) begin
                    livesNext = 3'(MAX_LIVES);
                end else begin
                    livesNext = livesSum[2:0];
                end
                if (gfc.aliensAtBottom) begin
                    livesNext = 3'd0;
                    stateNext = S_DONE;
                    lostNext  = 1'b1;
                end else if (livesSum == 4'd0) begin
                    stateNext = S_DONE;
                    lostNext  = 1'b1;
                end else if (aliensNext == 7'd0) begin
                    stateNext = S_DONE;
                    winNext   = 1'b1;
                end else if (hitTaken) begin
                    stateNext    = S_INVULN;
                    frameCntNext = '0;
                end else if ((state == S_INVULN) && gfc.startOfFrame) begin
                    frameCntNext = frameTick;
                    if (frameTick == CNT_W'(INVULN_FRAMES)) begin
                        stateNext    = S_PLAY;
                        frameCntNext = '0;
                    end
                end
            end
            S_DONE: begin
                stateNext = S_DONE;
            end
            default: begin
                stateNext = S_IDLE;
            end
        endcase
    end

    // State, counters and registered outputs; the key delay resets high so a held key cannot start a round
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state      <= S_IDLE;
            frameCnt   <= '0;
            lives      <= 3'(START_LIVES);
            aliens     <= 7'(ALIEN_COUNT);
            keyDly     <= 1'b1;
            startPulse <= 1'b0;
            lostPulse  <= 1'b0;
            winPulse   <= 1'b0;
            activeR    <= 1'b0;
            invulnR    <= 1'b0;
`ifdef EXTRA_LIFE_EN
            killCnt    <= '0;
`endif
        end else begin
            state      <= stateNext;
            frameCnt   <= frameCntNext;
            lives      <= livesNext;
            aliens     <= aliensNext;
            keyDly     <= gfc.startKey;
            startPulse <= startNext;
            lostPulse  <= lostNext;
            winPulse   <= winNext;
            activeR    <= (stateNext == S_PLAY) || (stateNext == S_INVULN);
            invulnR    <= (stateNext == S_INVULN);
`ifdef EXTRA_LIFE_EN
            killCnt    <= killNext;
`endif
        end
    end

endmodule
